intersection_arbiter: RTL and testbench
=======================================

INTERSECTION_ARBITER -- requirements
Module: intersection_arbiter

Interface
REQ-001 Parameter T_MIN, default 10: minimum green time, in ticks.
REQ-002 Parameter T_MAX, default 30: maximum green time when other phases are waiting, in ticks.
REQ-003 Parameter T_Y, default 3: yellow time, in ticks.
REQ-004 Parameter T_AR, default 1: all-red clearance time, in ticks.
REQ-005 Parameter HOME, default 0: phase index that rests in green when no requests are pending.
REQ-006 CLK  in  1  single system clock; all state changes on the rising edge.
REQ-007 RESET  in  1  asynchronous, active-low reset.
REQ-008 TICK  in  1  one-CLK-wide timing enable from the divider; all timers advance only when TICK=1.
REQ-009 REQ  in  4  per-phase request pulses or levels; bit i is phase i.
REQ-010 LAMP_G, LAMP_Y, LAMP_R  out  4 each  per-phase lamp drives.
REQ-011 PHASE  out  2  index of the phase currently served.
REQ-012 CNT_H, CNT_L  out  4 each  BCD tens and units of the remaining ticks in the current state.
REQ-013 EMG_REQ  in  1, and EMG_PHASE  in  2; both ports exist only when EMERGENCY_PREEMPT_EN is defined.

Function
REQ-014 FSM states are ALLRED, GREEN and YELLOW, with a tick timer of 8 bits.
REQ-015 The timer SHALL clear on every state entry, increment on TICK, and saturate at 99.
REQ-016 A state exits on the CLK edge where TICK=1 and the timer equals the state limit minus 1, so each state lasts exactly limit ticks.
REQ-017 Pending requests are latched: bit i is set by REQ[i]=1 on any CLK edge.
REQ-018 Pending bit i is cleared on the edge entering GREEN for phase i.
REQ-019 A REQ for the phase currently in GREEN is dropped; when set and clear coincide, clear wins.
REQ-020 ALLRED exits after T_AR ticks into GREEN.
REQ-021 On exit from ALLRED, the granted phase is the first pending phase in round-robin order, starting at PHASE+1 mod 4; if none is pending, HOME is granted.
REQ-022 GREEN exits to YELLOW when timer ≥ T_MIN-1 on a TICK with any other phase pending.
REQ-023 GREEN is forced to exit to YELLOW at T_MAX whenever any other phase is pending.
REQ-024 With no other phase pending, GREEN rests indefinitely; the timer saturates and the state does not exit.
REQ-025 YELLOW exits to ALLRED after T_Y ticks.
REQ-026 Lamps: the served phase shows G in GREEN and Y in YELLOW; every other phase shows R; in ALLRED all phases show R.
REQ-027 Exactly one lamp per phase SHALL be on in every cycle.
REQ-028 CNT SHALL show limit-1-timer for the state, where the GREEN limit is T_MAX, saturating at 0 and updating the same cycle as the timer.
REQ-029 Parameters SHALL satisfy 1 ≤ T_MIN ≤ T_MAX ≤ 99 and T_Y, T_AR ≥ 1.

Reset
REQ-030 On RESET=0, asynchronously: state=ALLRED, PHASE=HOME, timer=0, pending=0.
REQ-031 During reset, LAMP_R=4'hF, LAMP_G=LAMP_Y=0, and CNT shows T_AR-1.
REQ-032 Reset asserted mid-GREEN SHALL drop to all-red immediately with no yellow.

Configuration
REQ-033 The macro EMERGENCY_PREEMPT_EN SHALL control emergency preemption.
REQ-034 When defined and EMG_REQ=1 with a GREEN phase other than EMG_PHASE, the block SHALL enter YELLOW on the next edge, ignoring T_MIN.
REQ-035 After that YELLOW and ALLRED, EMG_PHASE SHALL be granted regardless of round-robin.
REQ-036 GREEN on EMG_PHASE SHALL be held while EMG_REQ=1, overriding T_MAX.
REQ-037 If EMG_REQ=1 while already in YELLOW or ALLRED, the sequence completes normally and then grants EMG_PHASE.
REQ-038 When the macro is undefined, the EMG_REQ and EMG_PHASE ports and all preemption logic are absent, and behaviour follows REQ-014 to REQ-029 only.

Structure
REQ-039 The shared package intersection_pkg SHALL hold the state encoding, the NUM_PHASES=4 constant, the lamp-bit constants and the default timing constants.
REQ-040 A sub-module bin2bcd99 SHALL convert the 7-bit remaining count to CNT_H/CNT_L, one instance.

Verification
REQ-041 Reset, then 2 ticks with no requests -> PHASE=0 green at tick 1; with no requests it rests: LAMP_G=4'b0001 indefinitely, CNT=00.
REQ-042 REQ=4'b0100 pulse at tick 3 of green on phase 0 -> YELLOW at tick 10 lasting 3 ticks, ALLRED for 1 tick, then GREEN phase 2 with the pending bit cleared.
REQ-043 REQ=4'b1010 held while green on phase 0 -> grant order phase 1, then 3, then 1 again, with each green lasting exactly 10 ticks.
REQ-044 With T_MIN=5, T_MAX=8: REQ[1] arrives at tick 6 -> exit to YELLOW on the same tick; REQ on the green phase itself is dropped and does not extend green.
REQ-045 RESET pulse mid-YELLOW -> all lamps R within the same cycle and PHASE=HOME; after release, the normal ALLRED to GREEN sequence follows.
REQ-046 With EMERGENCY_PREEMPT_EN defined: EMG_REQ=1, EMG_PHASE=3 at green tick 2 of phase 0 -> YELLOW on the next edge, then ALLRED, then phase 3 green held until EMG_REQ=0.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared constants for the intersection arbiter: state encoding, phase count,
// lamp masks, default timing and the round-robin grant helper.
package intersection_pkg;

    localparam int unsigned NUM_PHASES = 4;

    localparam int unsigned DEF_T_MIN = 10;
    localparam int unsigned DEF_T_MAX = 30;
    localparam int unsigned DEF_T_Y   = 3;
    localparam int unsigned DEF_T_AR  = 1;

    localparam logic [7:0] TIMER_SAT = 8'd99;

    localparam logic [1:0] ST_ALLRED = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;

    localparam logic [NUM_PHASES-1:0] LAMPS_ALL  = '1;
    localparam logic [NUM_PHASES-1:0] LAMPS_NONE = '0;

    // Returns {found, index} of the first requesting phase after cur, wrapping to cur last.
    function automatic logic [2:0] rr_pick(input logic [NUM_PHASES-1:0] req,
                                           input logic [1:0] cur);
        logic [2:0] pick;
        logic [1:0] idx;
        pick = '0;
        for (int unsigned i = 1; i <= NUM_PHASES; i++) begin
            idx = cur + 2'(i);
            if (req[idx] && !pick[2]) pick = {1'b1, idx};
        end
        return pick;
    endfunction

endpackage

// File: rtl/bin2bcd99.sv
// Converts a binary count in 0..99 into BCD tens and units digits.
module bin2bcd99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    always_comb begin
        tens = 4'(bin / 7'd10);
        ones = 4'(bin - 7'(tens) * 7'd10);
    end

endmodule

// File: rtl/intersection_arbiter.sv
// Four-phase traffic-light arbiter with latched requests and round-robin grants.
// Optional emergency preemption is built when EMERGENCY_PREEMPT_EN is defined.
module intersection_arbiter
    import intersection_pkg::*;
#(
    parameter int unsigned T_MIN = DEF_T_MIN,
    parameter int unsigned T_MAX = DEF_T_MAX,
    parameter int unsigned T_Y   = DEF_T_Y,
    parameter int unsigned T_AR  = DEF_T_AR,
    parameter int unsigned HOME  = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  TICK,
    input  logic [NUM_PHASES-1:0] REQ,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic                  EMG_REQ,
    input  logic [1:0]            EMG_PHASE,
`endif
    output logic [NUM_PHASES-1:0] LAMP_G,
    output logic [NUM_PHASES-1:0] LAMP_Y,
    output logic [NUM_PHASES-1:0] LAMP_R,
    output logic [1:0]            PHASE,
    output logic [3:0]            CNT_H,
    output logic [3:0]            CNT_L
);

    logic [1:0]            state, state_n;
    logic [1:0]            phase_n;
    logic [7:0]            timer;
    logic [NUM_PHASES-1:0] pending, pending_n;
    logic [NUM_PHASES-1:0] cur_mask, req_all, other;
    logic [2:0]            pick;
    logic                  go;
    logic [7:0]            limit_m1;
    logic [6:0]            remaining;
`ifdef EMERGENCY_PREEMPT_EN
    logic                  emg_pend, emg_pend_n;
    logic [1:0]            emg_ph, emg_ph_n;
`endif

    always_comb begin
        cur_mask  = 4'b0001 << PHASE;
        req_all   = pending | REQ;
        other     = req_all & ~cur_mask;
        pick      = rr_pick(req_all, PHASE);
        state_n   = state;
        phase_n   = PHASE;
        go        = 1'b0;
        pending_n = req_all;
`ifdef EMERGENCY_PREEMPT_EN
        emg_pend_n = emg_pend;
        emg_ph_n   = emg_ph;
        if (EMG_REQ) begin
            emg_pend_n = 1'b1;
            emg_ph_n   = EMG_PHASE;
        end
`endif
        case (state)
            ST_ALLRED: begin
                if (TICK && timer == 8'(T_AR - 1)) begin
                    go      = 1'b1;
                    state_n = ST_GREEN;
                    phase_n = pick[2] ? pick[1:0] : 2'(HOME);
`ifdef EMERGENCY_PREEMPT_EN
                    if (emg_pend_n) begin
                        phase_n    = emg_ph_n;
                        emg_pend_n = 1'b0;
                    end
`endif
                    pending_n = req_all & ~(4'b0001 << phase_n);
                end
            end
            ST_GREEN: begin
                // Requests for the phase already in green are discarded.
                pending_n = other;
`ifdef EMERGENCY_PREEMPT_EN
                if (EMG_REQ) begin
                    if (PHASE == EMG_PHASE) begin
                        emg_pend_n = 1'b0;
                    end else begin
                        go      = 1'b1;
                        state_n = ST_YELLOW;
                    end
                end else
`endif
                // T_MAX >= T_MIN, so the max-green limit is implied by this test.
                if (TICK && |other && timer >= 8'(T_MIN - 1)) begin
                    go      = 1'b1;
                    state_n = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (TICK && timer == 8'(T_Y - 1)) begin
                    go      = 1'b1;
                    state_n = ST_ALLRED;
                end
            end
            default: begin
                go      = 1'b1;
                state_n = ST_ALLRED;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= ST_ALLRED;
            PHASE   <= 2'(HOME);
            timer   <= '0;
            pending <= '0;
        end else begin
            state   <= state_n;
            PHASE   <= phase_n;
            pending <= pending_n;
            if (go)
                timer <= '0;
            else if (TICK && timer != TIMER_SAT)
                timer <= timer + 8'd1;
        end
    end

`ifdef EMERGENCY_PREEMPT_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            emg_pend <= 1'b0;
            emg_ph   <= '0;
        end else begin
            emg_pend <= emg_pend_n;
            emg_ph   <= emg_ph_n;
        end
    end
`endif

    always_comb begin
        LAMP_G = (state == ST_GREEN)  ? cur_mask : LAMPS_NONE;
        LAMP_Y = (state == ST_YELLOW) ? cur_mask : LAMPS_NONE;
        LAMP_R = LAMPS_ALL & ~(LAMP_G | LAMP_Y);
    end

    always_comb begin
        case (state)
            ST_GREEN:  limit_m1 = 8'(T_MAX - 1);
            ST_YELLOW: limit_m1 = 8'(T_Y - 1);
            default:   limit_m1 = 8'(T_AR - 1);
        endcase
        remaining = (timer >= limit_m1) ? '0 : 7'(limit_m1 - timer);
    end

    bin2bcd99 u_bcd (
        .bin  (remaining),
        .tens (CNT_H),
        .ones (CNT_L)
    );

endmodule

// File: tb/tb_intersection_arbiter.sv
// Directed self-checking bench for intersection_arbiter: default instance plus a
// short-timing instance (T_MIN=5, T_MAX=8, T_AR=2); EMERGENCY_PREEMPT_EN adds a preemption scenario.
module tb_intersection_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic [3:0] req_a = '0;
    logic [3:0] req_b = '0;
    logic [3:0] lg_a, ly_a, lr_a, ch_a, cl_a;
    logic [3:0] lg_b, ly_b, lr_b, ch_b, cl_b;
    logic [1:0] ph_a, ph_b;
`ifdef EMERGENCY_PREEMPT_EN
    logic       emg_req = 1'b0;
    logic [1:0] emg_phase = '0;
    logic       emg_off = 1'b0;
    logic [1:0] emg_off_ph = '0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intersection_arbiter dut_a (
        .CLK       (clk),
        .RESET     (rst_n),
        .TICK      (tick),
        .REQ       (req_a),
`ifdef EMERGENCY_PREEMPT_EN
        .EMG_REQ   (emg_req),
        .EMG_PHASE (emg_phase),
`endif
        .LAMP_G    (lg_a),
        .LAMP_Y    (ly_a),
        .LAMP_R    (lr_a),
        .PHASE     (ph_a),
        .CNT_H     (ch_a),
        .CNT_L     (cl_a)
    );

    intersection_arbiter #(.T_MIN(5), .T_MAX(8), .T_AR(2)) dut_b (
        .CLK       (clk),
        .RESET     (rst_n),
        .TICK      (tick),
        .REQ       (req_b),
`ifdef EMERGENCY_PREEMPT_EN
        .EMG_REQ   (emg_off),
        .EMG_PHASE (emg_off_ph),
`endif
        .LAMP_G    (lg_b),
        .LAMP_Y    (ly_b),
        .LAMP_R    (lr_b),
        .PHASE     (ph_b),
        .CNT_H     (ch_b),
        .CNT_L     (cl_b)
    );

    task automatic chk(input string tag, input bit sel_b, input logic [3:0] g,
                       input logic [3:0] y, input logic [1:0] ph, input logic [7:0] cnt);
        logic [3:0] og, oy, orr, r;
        logic [1:0] op;
        logic [7:0] oc;
        og  = sel_b ? lg_b : lg_a;
        oy  = sel_b ? ly_b : ly_a;
        orr = sel_b ? lr_b : lr_a;
        op  = sel_b ? ph_b : ph_a;
        oc  = sel_b ? {ch_b, cl_b} : {ch_a, cl_a};
        r   = ~(g | y);
        checks++;
        assert (og === g) else begin
            errors++;
            $error("FAIL %s lamp_g observed %b expected %b", tag, og, g);
        end
        checks++;
        assert (oy === y) else begin
            errors++;
            $error("FAIL %s lamp_y observed %b expected %b", tag, oy, y);
        end
        checks++;
        assert (orr === r) else begin
            errors++;
            $error("FAIL %s lamp_r observed %b expected %b", tag, orr, r);
        end
        checks++;
        assert (op === ph) else begin
            errors++;
            $error("FAIL %s phase observed %0d expected %0d", tag, op, ph);
        end
        checks++;
        assert (oc === cnt) else begin
            errors++;
            $error("FAIL %s cnt observed %h expected %h", tag, oc, cnt);
        end
    endtask

    // Reset is asserted between edges so the lamp check proves it acts asynchronously.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        tick  = 1'b0;
        req_a = '0;
        req_b = '0;
        #1;
        chk(tag, 1'b0, 4'b0000, 4'b0000, 2'd0, 8'h00);
        chk(tag, 1'b1, 4'b0000, 4'b0000, 2'd0, 8'h01);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(posedge clk);
            #1;
            tick = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Rest on HOME, timer saturation, exit from a saturated green.
        do_reset("rst_init");
        ticks(1);   chk("rest_green_t0", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h29);
        ticks(1);   chk("rest_green_t1", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h28);
        ticks(120); chk("rest_saturated", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h00);
        req_a = 4'b0010;
        idle_cycle();
        req_a = '0;
        chk("no_tick_hold", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h00);
        ticks(1);   chk("sat_exit_yellow", 1'b0, 4'b0000, 4'b0001, 2'd0, 8'h02);

        // Single pulse for phase 2 during green 0.
        do_reset("rst_pulse");
        ticks(2);
        req_a = 4'b0100;
        ticks(1);
        req_a = '0;
        ticks(7);   chk("pulse_green_t9", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h20);
        ticks(1);   chk("pulse_yellow", 1'b0, 4'b0000, 4'b0001, 2'd0, 8'h02);
        ticks(2);   chk("pulse_yellow_end", 1'b0, 4'b0000, 4'b0001, 2'd0, 8'h00);
        ticks(1);   chk("pulse_allred", 1'b0, 4'b0000, 4'b0000, 2'd0, 8'h00);
        ticks(1);   chk("pulse_green2", 1'b0, 4'b0100, 4'b0000, 2'd2, 8'h29);
        ticks(12);  chk("green2_rest", 1'b0, 4'b0100, 4'b0000, 2'd2, 8'h17);
        req_a = 4'b0001;
        idle_cycle();
        req_a = '0;
        ticks(1);   chk("green2_to_yellow", 1'b0, 4'b0000, 4'b0100, 2'd2, 8'h02);
        ticks(3);   chk("green2_allred", 1'b0, 4'b0000, 4'b0000, 2'd2, 8'h00);
        ticks(1);   chk("back_green0", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h29);
        ticks(15);  chk("pend2_cleared", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h14);

        // Held requests on phases 1 and 3: round-robin 1, 3, 1.
        do_reset("rst_rr");
        ticks(1);
        req_a = 4'b1010;
        ticks(9);   chk("rr_g0_t9", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h20);
        ticks(1);   chk("rr_y0", 1'b0, 4'b0000, 4'b0001, 2'd0, 8'h02);
        ticks(4);   chk("rr_g1", 1'b0, 4'b0010, 4'b0000, 2'd1, 8'h29);
        ticks(9);   chk("rr_g1_t9", 1'b0, 4'b0010, 4'b0000, 2'd1, 8'h20);
        ticks(1);   chk("rr_y1", 1'b0, 4'b0000, 4'b0010, 2'd1, 8'h02);
        ticks(4);   chk("rr_g3", 1'b0, 4'b1000, 4'b0000, 2'd3, 8'h29);
        ticks(9);   chk("rr_g3_t9", 1'b0, 4'b1000, 4'b0000, 2'd3, 8'h20);
        ticks(1);   chk("rr_y3", 1'b0, 4'b0000, 4'b1000, 2'd3, 8'h02);
        ticks(4);   chk("rr_g1_again", 1'b0, 4'b0010, 4'b0000, 2'd1, 8'h29);
        req_a = '0;

        // Short-timing instance: own-phase request dropped, late request exits at once.
        do_reset("rst_short");
        ticks(2);   chk("b_green0", 1'b1, 4'b0001, 4'b0000, 2'd0, 8'h07);
        req_b = 4'b0001;
        ticks(5);   chk("b_own_req_no_exit", 1'b1, 4'b0001, 4'b0000, 2'd0, 8'h02);
        req_b = 4'b0010;
        ticks(1);   chk("b_exit_same_tick", 1'b1, 4'b0000, 4'b0001, 2'd0, 8'h02);
        req_b = '0;
        ticks(3);   chk("b_allred_t0", 1'b1, 4'b0000, 4'b0000, 2'd0, 8'h01);
        ticks(1);   chk("b_allred_t1", 1'b1, 4'b0000, 4'b0000, 2'd0, 8'h00);
        ticks(1);   chk("b_green1", 1'b1, 4'b0010, 4'b0000, 2'd1, 8'h07);
        ticks(8);   chk("b_green1_rest", 1'b1, 4'b0010, 4'b0000, 2'd1, 8'h00);

        // Reset in the middle of yellow on phase 1.
        do_reset("rst_pre_yellow");
        ticks(1);
        req_a = 4'b0010;
        idle_cycle();
        req_a = '0;
        ticks(14);  chk("ry_green1", 1'b0, 4'b0010, 4'b0000, 2'd1, 8'h29);
        req_a = 4'b0001;
        idle_cycle();
        req_a = '0;
        ticks(11);  chk("ry_yellow1_t1", 1'b0, 4'b0000, 4'b0010, 2'd1, 8'h01);
        do_reset("rst_mid_yellow");
        ticks(1);   chk("ry_after_green0", 1'b0, 4'b0001, 4'b0000, 2'd0, 8'h29);

`ifdef EMERGENCY_PREEMPT_EN
        do_reset("rst_emg");
        ticks(2);
        emg_req   = 1'b1;
        emg_phase = 2'd3;
        idle_cycle(); chk("emg_preempt_yellow", 1'b0, 4'b0000, 4'b0001, 2'd0, 8'h02);
        ticks(3);     chk("emg_allred", 1'b0, 4'b0000, 4'b0000, 2'd0, 8'h00);
        ticks(1);     chk("emg_green3", 1'b0, 4'b1000, 4'b0000, 2'd3, 8'h29);
        req_a = 4'b0001;
        idle_cycle();
        req_a = '0;
        ticks(40);    chk("emg_hold", 1'b0, 4'b1000, 4'b0000, 2'd3, 8'h00);
        emg_req = 1'b0;
        ticks(1);     chk("emg_release", 1'b0, 4'b0000, 4'b1000, 2'd3, 8'h02);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1);
    end

endmodule
